// File: rtl/adder_share_pkg.sv
// Shared definitions for the time-multiplexed adder controller.
package adder_share_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_slice4.sv
// 4-bit ripple-carry adder slice with carry in and carry out.
module adder_slice4
  import adder_share_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               cout_o
);

  logic [SLICE_W:0] c;

  // Ripple the carry bit by bit through the slice.
  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int unsigned i = 0; i < SLICE_W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = c[SLICE_W];
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one 4-bit adder slice between two requesters, sequencing it over
// WIDTH/4 cycles with a registered carry. Round-robin arbitration.
// Define ADDER_SHARE_SUB_EN to add the req_sub port and A-B support.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
`ifdef ADDER_SHARE_SUB_EN
  input  logic [1:0]       req_sub,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH:0]   rsp_sum,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_e            state_q;
  logic              rr_ptr_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  a_q, b_q, sum_q, sum_d;
  logic              id_q;
  logic              sub_q;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [WIDTH:0]    rsp_sum_q;

  logic [1:0]        grant;
  logic              gnt_id;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic              sel_sub;
  logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
  logic              slice_cout;

  // Grant a lone requester directly; on contention the pointer decides.
  always_comb begin
    grant = '0;
    if (state_q == IDLE) begin
      if (req_valid == 2'b11) grant[rr_ptr_q] = 1'b1;
      else                    grant = req_valid;
    end
  end

  assign gnt_id = grant[1];
  assign sel_a  = gnt_id ? req_a1 : req_a0;
  assign sel_b  = gnt_id ? req_b1 : req_b0;
`ifdef ADDER_SHARE_SUB_EN
  assign sel_sub = req_sub[gnt_id];
`else
  assign sel_sub = 1'b0;
`endif

  // Feed the current slice to the adder; subtraction inverts B.
  always_comb begin
    slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
    slice_b = b_q[idx_q*SLICE_W +: SLICE_W] ^ {SLICE_W{sub_q}};
    sum_d   = sum_q;
    sum_d[idx_q*SLICE_W +: SLICE_W] = slice_sum;
  end

  adder_slice4 u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // Controller FSM: accept, iterate slices, hold result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      id_q        <= 1'b0;
      sub_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            a_q      <= sel_a;
            b_q      <= sel_b;
            id_q     <= gnt_id;
            sub_q    <= sel_sub;
            carry_q  <= sel_sub;
            idx_q    <= '0;
            rr_ptr_q <= ~gnt_id;
            state_q  <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= slice_cout;
          if (idx_q == LAST_IDX) begin
            rsp_sum_q   <= {slice_cout, sum_d};
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            idx_q       <= '0;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl (WIDTH=16). Exercises the
// subtract path when ADDER_SHARE_SUB_EN is defined.
module tb_adder_share_ctrl;

  localparam int W = 16;
  localparam int NSL = W / 4;

  typedef struct packed {
    logic        id;
    logic [W:0]  sum;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
`ifdef ADDER_SHARE_SUB_EN
  logic [1:0]   req_sub;
`endif
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W:0]   rsp_sum;
  logic         busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sbq[$];

  localparam logic [W-1:0] BA [5] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hA5A5};
  localparam logic [W-1:0] BB [5] = '{16'h1111, 16'h0001, 16'hFFFF, 16'h0000, 16'h5A5A};

  always #5 clk = ~clk;

  adder_share_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
`ifdef ADDER_SHARE_SUB_EN
    .req_sub   (req_sub),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .busy      (busy)
  );

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input bit sub);
    logic [W:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + 17'd1;
    else     r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

  task automatic set_req(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit sub);
    if (id) begin req_a1 = a; req_b1 = b; end
    else    begin req_a0 = a; req_b0 = b; end
`ifdef ADDER_SHARE_SUB_EN
    req_sub[id] = sub;
`endif
    req_valid[id] = 1'b1;
  endtask

  function automatic exp_t mk_exp(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input bit sub);
    exp_t e;
    e.id  = id;
    e.sum = model(a, b, sub);
    return e;
  endfunction

  // Called at a negedge; returns at the accepting posedge.
  task automatic wait_accept(output bit ok, output logic [1:0] rdy);
    ok = 1'b0; rdy = 2'b00;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        rdy = req_ready; ok = 1'b1;
        @(posedge clk);
        return;
      end
      @(negedge clk);
    end
  endtask

  // Called at the first negedge after accept; lat = posedges since accept.
  task automatic wait_rsp(output bit ok, output int lat);
    ok = 1'b0; lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid === 1'b1) begin ok = 1'b1; return; end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
`ifdef ADDER_SHARE_SUB_EN
    req_sub = '0;
`endif
    repeat (3) @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (rsp_sum !== '0) begin n_fail++; $display("FAIL reset_rsp_sum got=%h exp=0", rsp_sum); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    bit ok; logic [1:0] rdy; int lat; exp_t e;
    for (int r = 0; r < 4; r++) begin
      bit expid = bit'(r % 2);
      logic [W-1:0] a0 = W'($urandom), b0 = W'($urandom), a1 = W'($urandom), b1 = W'($urandom);
      set_req(1'b0, a0, b0, 1'b0);
      set_req(1'b1, a1, b1, 1'b0);
      wait_accept(ok, rdy);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL arb_accept_timeout round=%0d", r); req_valid = '0; return; end
      n_checks++;
      if (rdy !== (expid ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL arb_grant round=%0d got=%b exp=%b", r, rdy, expid ? 2'b10 : 2'b01);
      end
      sbq.push_back(expid ? mk_exp(1'b1, a1, b1, 1'b0) : mk_exp(1'b0, a0, b0, 1'b0));
      @(negedge clk);
      wait_rsp(ok, lat);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL arb_rsp_timeout round=%0d", r); req_valid = '0; return; end
      e = sbq.pop_front();
      n_checks++; if (rsp_id !== e.id) begin n_fail++; $display("FAIL arb_rsp_id round=%0d got=%b exp=%b", r, rsp_id, e.id); end
      n_checks++; if (rsp_sum !== e.sum) begin n_fail++; $display("FAIL arb_rsp_sum round=%0d got=%h exp=%h", r, rsp_sum, e.sum); end
      ack_rsp();
    end
    req_valid = '0;
  endtask

  task automatic test_basic();
    bit ok; logic [1:0] rdy; int lat; exp_t e;
    for (int k = 0; k < 5; k++) begin
      bit id = bit'(k % 2);
      set_req(id, BA[k], BB[k], 1'b0);
      wait_accept(ok, rdy);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL basic_accept_timeout case=%0d", k); req_valid = '0; return; end
      sbq.push_back(mk_exp(id, BA[k], BB[k], 1'b0));
      @(negedge clk);
      // Operands and valid change after accept; the latched op must be unaffected.
      req_valid = '0;
      req_a0 = W'($urandom); req_b0 = W'($urandom); req_a1 = W'($urandom); req_b1 = W'($urandom);
      wait_rsp(ok, lat);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL basic_rsp_timeout case=%0d", k); return; end
      e = sbq.pop_front();
      n_checks++; if (lat != NSL) begin n_fail++; $display("FAIL basic_latency case=%0d got=%0d exp=%0d", k, lat, NSL); end
      n_checks++; if (rsp_id !== e.id) begin n_fail++; $display("FAIL basic_rsp_id case=%0d got=%b exp=%b", k, rsp_id, e.id); end
      n_checks++; if (rsp_sum !== e.sum) begin n_fail++; $display("FAIL basic_rsp_sum case=%0d got=%h exp=%h", k, rsp_sum, e.sum); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_done case=%0d got=%b exp=1", k, busy); end
      ack_rsp();
      n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL basic_after_ack case=%0d rsp_valid=%b busy=%b exp=0,0", k, rsp_valid, busy);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok; logic [1:0] rdy; int lat; exp_t e;
    set_req(1'b0, 16'h0F0F, 16'h00F1, 1'b0);
    wait_accept(ok, rdy);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_accept_timeout"); req_valid = '0; return; end
    sbq.push_back(mk_exp(1'b0, 16'h0F0F, 16'h00F1, 1'b0));
    @(negedge clk);
    set_req(1'b0, 16'h1111, 16'h2222, 1'b0);
    set_req(1'b1, 16'h3333, 16'h4444, 1'b0);
    wait_rsp(ok, lat);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_rsp_timeout"); req_valid = '0; return; end
    e = sbq.pop_front();
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", c, rsp_valid); end
      n_checks++; if (rsp_sum !== e.sum) begin n_fail++; $display("FAIL bp_sum cyc=%0d got=%h exp=%h", c, rsp_sum, e.sum); end
      n_checks++; if (rsp_id !== e.id) begin n_fail++; $display("FAIL bp_id cyc=%0d got=%b exp=%b", c, rsp_id, e.id); end
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_req_ready cyc=%0d got=%b exp=00", c, req_ready); end
      @(negedge clk);
    end
    req_valid = '0;
    ack_rsp();
  endtask

  task automatic test_reset_midrun();
    bit ok; logic [1:0] rdy; int lat; exp_t e;
    // Granting requester 0 leaves the pointer at 1; reset must return it to 0.
    set_req(1'b0, 16'hAAAA, 16'h5555, 1'b0);
    wait_accept(ok, rdy);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mr_accept_timeout"); req_valid = '0; return; end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mr_busy got=%b exp=0", busy); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mr_rsp_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (rsp_sum !== '0) begin n_fail++; $display("FAIL mr_rsp_sum got=%h exp=0", rsp_sum); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(1'b0, 16'h8001, 16'h8003, 1'b0);
    set_req(1'b1, 16'h0001, 16'h0002, 1'b0);
    wait_accept(ok, rdy);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mr_post_accept_timeout"); req_valid = '0; return; end
    n_checks++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL mr_rr_reset got=%b exp=01", rdy); end
    sbq.push_back(mk_exp(1'b0, 16'h8001, 16'h8003, 1'b0));
    @(negedge clk);
    req_valid = '0;
    wait_rsp(ok, lat);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mr_rsp_timeout"); return; end
    e = sbq.pop_front();
    n_checks++; if (lat != NSL) begin n_fail++; $display("FAIL mr_latency got=%0d exp=%0d", lat, NSL); end
    n_checks++; if (rsp_sum !== e.sum) begin n_fail++; $display("FAIL mr_rsp_sum got=%h exp=%h", rsp_sum, e.sum); end
    n_checks++; if (rsp_id !== e.id) begin n_fail++; $display("FAIL mr_rsp_id got=%b exp=%b", rsp_id, e.id); end
    ack_rsp();
  endtask

`ifdef ADDER_SHARE_SUB_EN
  localparam logic [W-1:0] SA [4] = '{16'h0005, 16'h0007, 16'h1234, 16'h00FF};
  localparam logic [W-1:0] SB [4] = '{16'h0007, 16'h0005, 16'h1234, 16'h0F00};
  localparam bit           SS [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  task automatic test_sub();
    bit ok; logic [1:0] rdy; int lat; exp_t e;
    for (int k = 0; k < 4; k++) begin
      bit id = bit'((k + 1) % 2);
      set_req(id, SA[k], SB[k], SS[k]);
      wait_accept(ok, rdy);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL sub_accept_timeout case=%0d", k); req_valid = '0; return; end
      sbq.push_back(mk_exp(id, SA[k], SB[k], SS[k]));
      @(negedge clk);
      req_valid = '0;
      req_sub = ~req_sub;
      wait_rsp(ok, lat);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL sub_rsp_timeout case=%0d", k); return; end
      e = sbq.pop_front();
      n_checks++; if (rsp_sum !== e.sum) begin n_fail++; $display("FAIL sub_rsp_sum case=%0d got=%h exp=%h", k, rsp_sum, e.sum); end
      n_checks++; if (rsp_id !== e.id) begin n_fail++; $display("FAIL sub_rsp_id case=%0d got=%b exp=%b", k, rsp_id, e.id); end
      ack_rsp();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_arbitration();
    test_basic();
    test_backpressure();
    test_reset_midrun();
`ifdef ADDER_SHARE_SUB_EN
    test_sub();
`endif
    n_checks++;
    if (sbq.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d exp=0", sbq.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
